// File: rtl/lv_owt_pkg.sv
// Shared definitions for the LV-side one-wire transport (OWT) blocks:
// the receive FSM state encoding, the CRC-8 polynomial, and the default
// field widths that the transmitter and the shadow-register stage also use.
package lv_owt_pkg;

    localparam int OWT_CMD_BIT_NUM_DEF  = 8;
    localparam int OWT_ADCD_BIT_NUM_DEF = 20;
    localparam int OWT_CLK_PER_BIT_DEF  = 16;
    localparam int OWT_CRC_W_DEF        = 8;

    // x^8 + x^2 + x + 1
    localparam logic [7:0] OWT_CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        OWT_ST_IDLE  = 3'd0,
        OWT_ST_START = 3'd1,
        OWT_ST_CMD   = 3'd2,
        OWT_ST_DATA  = 3'd3,
        OWT_ST_CRC   = 3'd4,
        OWT_ST_STOP  = 3'd5,
        OWT_ST_BREAK = 3'd6
    } owt_rx_st_e;

    // One MSB-first serial step of the CRC-8 LFSR.
    function automatic logic [7:0] owt_crc8_step(input logic [7:0] crc, input logic bit_in);
        return {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_in}} & OWT_CRC_POLY);
    endfunction

endpackage

// File: rtl/lv_owt_crc8.sv
// Serial CRC-8 LFSR (poly 0x07, init 0x00), fed MSB first one bit per
// bit_en strobe. clear has priority and returns the register to the init value.
module lv_owt_crc8
    import lv_owt_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: clear, advance by one bit, or hold.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (bit_en) begin
            crc_d = owt_crc8_step(crc_q, bit_in);
        end
    end

    // CRC register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/lv_owt_rx.sv
// LV-side OWT frame receiver: synchronizes and oversamples the return line
// from the HV die, deserializes start/cmd/data/[crc]/stop (MSB first) and
// reports each completed frame with a one-cycle ack plus an error status.
// Build option: define LV_OWT_RX_CRC_EN to include the CRC field and checker.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge with rx enabled
// START  | half-bit wait, then confirm start bit (reject glitches)
// CMD    | shifting in command bits, one per bit period at mid-bit
// DATA   | shifting in payload bits
// CRC    | shifting in received CRC field (CRC build only)
// STOP   | sampling stop bit, raising ack and status
// BREAK  | stop bit was low; wait for the line to return high
module lv_owt_rx
    import lv_owt_pkg::*;
#(
    parameter int OWT_CMD_BIT_NUM  = OWT_CMD_BIT_NUM_DEF,
    parameter int OWT_ADCD_BIT_NUM = OWT_ADCD_BIT_NUM_DEF,
    parameter int CLK_PER_BIT      = OWT_CLK_PER_BIT_DEF,
    parameter int OWT_CRC_W        = OWT_CRC_W_DEF
)
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_owt_rx,
    input  logic                        i_rx_en,
    output logic                        o_owt_rx_ack,
    output logic [OWT_CMD_BIT_NUM-1:0]  o_owt_rx_cmd,
    output logic [OWT_ADCD_BIT_NUM-1:0] o_owt_rx_data,
    output logic                        o_owt_rx_status,
    output logic                        o_owt_rx_busy
);

    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int TW       = $clog2(CLK_PER_BIT);
    localparam int MAXW_CD  = (OWT_CMD_BIT_NUM > OWT_ADCD_BIT_NUM) ? OWT_CMD_BIT_NUM : OWT_ADCD_BIT_NUM;
    localparam int MAXW     = (MAXW_CD > OWT_CRC_W) ? MAXW_CD : OWT_CRC_W;
    localparam int BCW      = $clog2(MAXW);

    logic sync1_q, sync2_q, prev_q;
    logic rx_s, rx_fall;

    owt_rx_st_e             state_q, state_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [BCW-1:0]         bcnt_q, bcnt_d;
    logic                   tmr_tc;

    logic [OWT_CMD_BIT_NUM-1:0]  cmd_sh_q, cmd_sh_d;
    logic [OWT_ADCD_BIT_NUM-1:0] data_sh_q, data_sh_d;

    logic                        ack_q, ack_d;
    logic [OWT_CMD_BIT_NUM-1:0]  cmd_q, cmd_d;
    logic [OWT_ADCD_BIT_NUM-1:0] data_q, data_d;
    logic                        status_q, status_d;
    logic                        busy_q, busy_d;
    logic                        crc_mismatch;

`ifdef LV_OWT_RX_CRC_EN
    logic [OWT_CRC_W-1:0] crc_sh_q, crc_sh_d;
    logic                 crc_clear, crc_bit_en;
    logic [7:0]           crc_calc;

    lv_owt_crc8 u_crc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (crc_clear),
        .bit_en  (crc_bit_en),
        .bit_in  (rx_s),
        .crc_out (crc_calc)
    );

    assign crc_mismatch = (crc_calc != crc_sh_q);
`else
    assign crc_mismatch = 1'b0;
`endif

    assign rx_s    = sync2_q;
    assign rx_fall = prev_q & ~sync2_q;
    assign tmr_tc  = (tmr_q == '0);

    // Two-flop synchronizer plus delayed copy for falling-edge detection; idle high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_owt_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Frame FSM, bit-period down-counter, field shift registers and result capture.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_tc ? tmr_q : tmr_q - TW'(1);
        bcnt_d    = bcnt_q;
        cmd_sh_d  = cmd_sh_q;
        data_sh_d = data_sh_q;
        ack_d     = 1'b0;
        cmd_d     = cmd_q;
        data_d    = data_q;
        status_d  = status_q;
`ifdef LV_OWT_RX_CRC_EN
        crc_sh_d   = crc_sh_q;
        crc_clear  = 1'b0;
        crc_bit_en = 1'b0;
`endif

        case (state_q)
            OWT_ST_IDLE: begin
`ifdef LV_OWT_RX_CRC_EN
                crc_clear = 1'b1;
`endif
                if (rx_fall) begin
                    state_d = OWT_ST_START;
                    tmr_d   = TW'(HALF_BIT - 1);
                end
            end
            OWT_ST_START: begin
                if (tmr_tc) begin
                    if (rx_s) begin
                        state_d = OWT_ST_IDLE;
                    end else begin
                        state_d = OWT_ST_CMD;
                        tmr_d   = TW'(CLK_PER_BIT - 1);
                        bcnt_d  = BCW'(OWT_CMD_BIT_NUM - 1);
                    end
                end
            end
            OWT_ST_CMD: begin
                if (tmr_tc) begin
                    cmd_sh_d = {cmd_sh_q[OWT_CMD_BIT_NUM-2:0], rx_s};
                    tmr_d    = TW'(CLK_PER_BIT - 1);
`ifdef LV_OWT_RX_CRC_EN
                    crc_bit_en = 1'b1;
`endif
                    if (bcnt_q == '0) begin
                        state_d = OWT_ST_DATA;
                        bcnt_d  = BCW'(OWT_ADCD_BIT_NUM - 1);
                    end else begin
                        bcnt_d = bcnt_q - BCW'(1);
                    end
                end
            end
            OWT_ST_DATA: begin
                if (tmr_tc) begin
                    data_sh_d = {data_sh_q[OWT_ADCD_BIT_NUM-2:0], rx_s};
                    tmr_d     = TW'(CLK_PER_BIT - 1);
`ifdef LV_OWT_RX_CRC_EN
                    crc_bit_en = 1'b1;
                    if (bcnt_q == '0) begin
                        state_d = OWT_ST_CRC;
                        bcnt_d  = BCW'(OWT_CRC_W - 1);
                    end else begin
                        bcnt_d = bcnt_q - BCW'(1);
                    end
`else
                    if (bcnt_q == '0) begin
                        state_d = OWT_ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q - BCW'(1);
                    end
`endif
                end
            end
`ifdef LV_OWT_RX_CRC_EN
            OWT_ST_CRC: begin
                if (tmr_tc) begin
                    crc_sh_d = {crc_sh_q[OWT_CRC_W-2:0], rx_s};
                    tmr_d    = TW'(CLK_PER_BIT - 1);
                    if (bcnt_q == '0) begin
                        state_d = OWT_ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q - BCW'(1);
                    end
                end
            end
`endif
            OWT_ST_STOP: begin
                if (tmr_tc) begin
                    ack_d    = 1'b1;
                    cmd_d    = cmd_sh_q;
                    data_d   = data_sh_q;
                    status_d = ~rx_s | crc_mismatch;
                    state_d  = rx_s ? OWT_ST_IDLE : OWT_ST_BREAK;
                end
            end
            OWT_ST_BREAK: begin
                if (rx_s) begin
                    state_d = OWT_ST_IDLE;
                end
            end
            default: begin
                state_d = OWT_ST_IDLE;
            end
        endcase

        // Disable aborts any frame in flight; results from the last good ack stay visible.
        if (!i_rx_en) begin
            state_d  = OWT_ST_IDLE;
            ack_d    = 1'b0;
            cmd_d    = cmd_q;
            data_d   = data_q;
            status_d = status_q;
        end

        busy_d = (state_d != OWT_ST_IDLE) && (state_d != OWT_ST_START);
    end

    // FSM, counters, shift registers and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= OWT_ST_IDLE;
            tmr_q     <= '0;
            bcnt_q    <= '0;
            cmd_sh_q  <= '0;
            data_sh_q <= '0;
            ack_q     <= 1'b0;
            cmd_q     <= '0;
            data_q    <= '0;
            status_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef LV_OWT_RX_CRC_EN
            crc_sh_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bcnt_q    <= bcnt_d;
            cmd_sh_q  <= cmd_sh_d;
            data_sh_q <= data_sh_d;
            ack_q     <= ack_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            status_q  <= status_d;
            busy_q    <= busy_d;
`ifdef LV_OWT_RX_CRC_EN
            crc_sh_q  <= crc_sh_d;
`endif
        end
    end

    assign o_owt_rx_ack    = ack_q;
    assign o_owt_rx_cmd    = cmd_q;
    assign o_owt_rx_data   = data_q;
    assign o_owt_rx_status = status_q;
    assign o_owt_rx_busy   = busy_q;

endmodule

// File: tb/tb_lv_owt_rx.sv
// Self-checking bench for lv_owt_rx. Frames are built bit by bit from
// directed and $urandom fields; expected cmd/data/status come from a
// CRC computed by polynomial long division over the message.
module tb_lv_owt_rx;
    import lv_owt_pkg::*;

    localparam int N  = 16;
    localparam int H  = N / 2;
    localparam int CW = 8;
    localparam int DW = 20;
`ifdef LV_OWT_RX_CRC_EN
    localparam int KW     = 8;
    localparam bit CRC_ON = 1'b1;
`else
    localparam int KW     = 0;
    localparam bit CRC_ON = 1'b0;
`endif
    localparam int FRAME_LAT = (1 + CW + DW + KW) * N + H + 4;

    logic          clk;
    logic          rst_n;
    logic          pin;
    logic          rx_en;
    logic          ack;
    logic [CW-1:0] cmd;
    logic [DW-1:0] data;
    logic          status;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ack_cnt  = 0;
    int ack_cyc  = 0;
    int busy_cnt = 0;
    int fstart   = 0;

    lv_owt_rx dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_owt_rx        (pin),
        .i_rx_en         (rx_en),
        .o_owt_rx_ack    (ack),
        .o_owt_rx_cmd    (cmd),
        .o_owt_rx_data   (data),
        .o_owt_rx_status (status),
        .o_owt_rx_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference CRC: remainder of {cmd,data} * x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input logic [CW-1:0] c, input logic [DW-1:0] d);
        logic [CW+DW+7:0] m;
        m = {c, d, 8'h00};
        for (int i = CW + DW + 7; i >= 8; i--) begin
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        pin = b;
        repeat (N) @(posedge clk);
        #1;
    endtask

    // Drives start, fields and stop. stop_low > 0 holds the stop bit low for that
    // many bit periods (line left low). drop_at / rst_at are bit indices at which
    // the enable drops or reset asserts (reset then stays asserted).
    task automatic send_frame(input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic [7:0] k, input int stop_low,
                              input int drop_at, input int rst_at);
        logic q[$];
        q.push_back(1'b0);
        for (int i = CW - 1; i >= 0; i--) q.push_back(c[i]);
        for (int i = DW - 1; i >= 0; i--) q.push_back(d[i]);
        if (CRC_ON) for (int i = 7; i >= 0; i--) q.push_back(k[i]);
        fstart = cyc;
        foreach (q[i]) begin
            if (i == drop_at) rx_en = 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_ack", ack, 0);
                chk("rst_mid_cmd", cmd, 0);
                chk("rst_mid_data", data, 0);
                chk("rst_mid_status", status, 0);
                chk("rst_mid_busy", busy, 0);
            end
            drive_bit(q[i]);
        end
        if (stop_low == 0) drive_bit(1'b1);
        else repeat (stop_low) drive_bit(1'b0);
    endtask

    task automatic check_frame(input string tag, input int a0, input logic [CW-1:0] c,
                               input logic [DW-1:0] d, input logic [7:0] k, input logic stop_err);
        logic exp_st;
        exp_st = stop_err | (CRC_ON & (crc_ref(c, d) != k));
        chk({tag, "_ack"}, ack_cnt - a0, 1);
        chk({tag, "_cmd"}, cmd, c);
        chk({tag, "_data"}, data, d);
        chk({tag, "_status"}, status, exp_st);
    endtask

    initial begin
        logic [CW-1:0] c;
        logic [DW-1:0] d, d2;
        logic [7:0]    k;
        int a0, b0, lat;

        rst_n = 1'b0;
        pin   = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", ack, 0);
        chk("reset_cmd", cmd, 0);
        chk("reset_data", data, 0);
        chk("reset_status", status, 0);
        chk("reset_busy", busy, 0);
        chk("reset_state", dut.state_q, OWT_ST_IDLE);
        rst_n = 1'b1;
        drive_bit(1'b1);

        // Good frame with latency check
        a0 = ack_cnt;
        k  = crc_ref(8'h9F, 20'hABCDE);
        send_frame(8'h9F, 20'hABCDE, k, 0, -1, -1);
        drive_bit(1'b1);
        check_frame("good", a0, 8'h9F, 20'hABCDE, k, 1'b0);
        lat = ack_cyc - fstart;
        checks++;
        assert (lat >= FRAME_LAT - 1 && lat <= FRAME_LAT + 1) else begin
            errors++;
            $error("FAIL latency: observed %0d expected %0d +/-1", lat, FRAME_LAT);
        end

        // One data bit flipped, CRC field of the original payload
        a0 = ack_cnt;
        d2 = 20'hABCDE ^ 20'h00400;
        send_frame(8'h9F, d2, k, 0, -1, -1);
        drive_bit(1'b1);
        check_frame("flip", a0, 8'h9F, d2, k, 1'b0);

        // Stop bit held low for 3 bit periods
        c  = 8'($urandom);
        d  = 20'($urandom);
        k  = crc_ref(c, d);
        a0 = ack_cnt;
        send_frame(c, d, k, 3, -1, -1);
        check_frame("brk", a0, c, d, k, 1'b1);
        chk("brk_busy_low_line", busy, 1);
        drive_bit(1'b1);
        chk("brk_busy_after", busy, 0);
        chk("brk_state_idle", dut.state_q, OWT_ST_IDLE);
        c  = 8'($urandom);
        d  = 20'($urandom);
        k  = crc_ref(c, d);
        a0 = ack_cnt;
        send_frame(c, d, k, 0, -1, -1);
        drive_bit(1'b1);
        check_frame("after_brk", a0, c, d, k, 1'b0);

        // 5-cycle low glitch on an idle line
        a0 = ack_cnt;
        b0 = busy_cnt;
        pin = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pin = 1'b1;
        repeat (2 * N) @(posedge clk);
        #1;
        chk("glitch_ack", ack_cnt - a0, 0);
        chk("glitch_busy", busy_cnt - b0, 0);
        chk("glitch_state", dut.state_q, OWT_ST_IDLE);

        // Enable dropped during DATA: no ack, outputs hold
        a0 = ack_cnt;
        send_frame(8'h3C, 20'h12345, crc_ref(8'h3C, 20'h12345), 0, 15, -1);
        drive_bit(1'b1);
        chk("drop_ack", ack_cnt - a0, 0);
        chk("drop_cmd_hold", cmd, c);
        chk("drop_data_hold", data, d);
        chk("drop_busy", busy, 0);
        rx_en = 1'b1;
        drive_bit(1'b1);
        c  = 8'($urandom);
        d  = 20'($urandom);
        k  = crc_ref(c, d);
        a0 = ack_cnt;
        send_frame(c, d, k, 0, -1, -1);
        drive_bit(1'b1);
        check_frame("after_drop", a0, c, d, k, 1'b0);

        // Reset asserted mid-CMD
        a0 = ack_cnt;
        send_frame(8'hA5, 20'h0F0F0, crc_ref(8'hA5, 20'h0F0F0), 0, -1, 4);
        chk("rst_no_ack", ack_cnt - a0, 0);
        drive_bit(1'b1);
        rst_n = 1'b1;
        drive_bit(1'b1);
        c  = 8'($urandom);
        d  = 20'($urandom);
        k  = crc_ref(c, d);
        a0 = ack_cnt;
        send_frame(c, d, k, 0, -1, -1);
        drive_bit(1'b1);
        check_frame("after_rst", a0, c, d, k, 1'b0);

        // Random frames, some with a corrupted CRC field
        for (int n = 0; n < 5; n++) begin
            c  = 8'($urandom);
            d  = 20'($urandom);
            k  = crc_ref(c, d);
            if (n[0]) k = k ^ 8'(1 << $urandom_range(7, 0));
            a0 = ack_cnt;
            send_frame(c, d, k, 0, -1, -1);
            drive_bit(1'b1);
            check_frame("rand", a0, c, d, k, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
